// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: operands captured on the accepting edge, result and one-cycle done after WIDTH more edges.
// No backpressure: start is honoured only in IDLE, so a request made while busy or done is dropped, not queued.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             c;
  logic             c_nxt;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // One full-adder step built from two half adders; the carry-out is the OR of their generates.
  logic h1, g1, s_bit, g2;
  always_comb begin
    h1      = a_sh[0] ^ b_sh[0];
    g1      = a_sh[0] & b_sh[0];
    s_bit   = h1 ^ c;
    g2      = h1 & c;
    c_nxt   = g1 | g2;
    res_nxt = {s_bit, res[WIDTH-1:1]};
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_nxt;
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          // sum/carry move only here, on the edge that enters DONE.
          if (last_bit) begin
            sum   <= res_nxt;
            carry <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  first operand, captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  second operand, captured on the accepting edge.
REQ-007 Port: busy  output  1  high while bits are being processed (RUN state).
REQ-008 Port: done  output  1  one-cycle pulse marking a new result on sum/carry.
REQ-009 Port: sum  output  WIDTH  result, low WIDTH bits of a+b.
REQ-010 Port: carry  output  1  carry-out of a+b (bit WIDTH).

Function
REQ-011 The block SHALL add bit-serially, LSB first, one bit per clock, using a single 1-bit carry register (half-adder pair plus carry OR per bit).
REQ-012 FSM states SHALL be IDLE, RUN, DONE; no other reachable states.
REQ-013 IDLE, start=1 at edge T: capture a, b into shift registers, clear carry register, clear bit counter, go to RUN.
REQ-014 IDLE, start=0: remain in IDLE; sum/carry hold.
REQ-015 RUN, each edge: s = a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0], b_sh[0], c); s shifted into result register from the MSB end; a_sh, b_sh shift right; counter increments.
REQ-016 RUN SHALL process exactly WIDTH bits, at edges T+1 .. T+WIDTH; at edge T+WIDTH go to DONE and load sum <= result register, carry <= final carry register.
REQ-017 DONE: done=1 for exactly one cycle (between edges T+WIDTH and T+WIDTH+1); unconditional return to IDLE at edge T+WIDTH+1.
REQ-018 busy SHALL be 1 exactly while in RUN (WIDTH cycles), 0 in IDLE and DONE.
REQ-019 Latency: operands accepted at edge T -> result valid and done=1 after edge T+WIDTH; next start accepted no earlier than edge T+WIDTH+1.
REQ-020 start while in RUN or DONE SHALL be ignored (no restart, no queuing); changes on a/b after capture SHALL NOT affect the result.
REQ-021 sum and carry SHALL change only on the edge entering DONE and hold that value until the next DONE or reset.
REQ-022 Result SHALL equal (a+b) mod 2^(WIDTH+1) split as {carry,sum} for every operand pair, including all-ones overflow.
REQ-023 start held high continuously: a new addition begins at each IDLE cycle, giving one result every WIDTH+2 cycles.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, carry=0, and clear shift registers, counter and carry register.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse and no sum/carry update; reset has priority over start.
REQ-026 First start after rst_n returns high SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-027 WIDTH=8, a=0x00, b=0x00, start 1 cycle -> busy high 8 cycles, done pulse after edge T+8, sum=0x00, carry=0.
REQ-028 a=0xFF, b=0x01 -> sum=0x00, carry=1 (full carry ripple across all 8 serial steps).
REQ-029 a=0xA5, b=0x5A -> sum=0xFF, carry=0; then a=0xFF, b=0xFF -> sum=0xFE, carry=1; sum/carry stable between the two done pulses.
REQ-030 start=1 pulsed at T+3 during RUN with different a/b -> ignored; result of first operands only; exactly one done pulse.
REQ-031 rst_n=0 for one edge at T+4 of an addition -> busy=0, sum=0, carry=0, no done; following start with a=0x12, b=0x34 -> sum=0x46, carry=0.
REQ-032 WIDTH=4 exhaustive: all 256 a/b pairs back-to-back with start held high -> every {carry,sum} equals a+b, one done every 6 cycles.
